// File: rtl/spike_aer_encoder_if.sv
// Address-event bus between the AER encoder and its downstream consumer.
// Carries one event per valid/ready handshake: neuron address plus frame timestamp.
// Ports: master drives aer_valid/aer_addr/aer_ts and samples aer_ready; slave is the mirror.
interface spike_aer_encoder_if #(
  parameter int AW  = 2,
  parameter int TSW = 8
);
  logic           aer_valid;
  logic           aer_ready;
  logic [AW-1:0]  aer_addr;
  logic [TSW-1:0] aer_ts;

  modport master (
    output aer_valid,
    output aer_addr,
    output aer_ts,
    input  aer_ready
  );

  modport slave (
    input  aer_valid,
    input  aer_addr,
    input  aer_ts,
    output aer_ready
  );
endinterface

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: serialises each frame's spike vector into address events, lowest index first.
// Latency: first event one cycle after an accepted frame_tick, then one event per cycle with no bubbles.
// Backpressure: event held stable while aer_ready is low; frame_ticks arriving mid-frame are dropped and counted.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   reset_i        synchronous active-high reset
//   enable_i       encoder enable; low aborts the current frame and ignores frame_ticks
//   frame_tick_i   one-cycle end-of-frame pulse, spikearray_i valid in the same cycle
//   spikearray_i   per-neuron spike flags of the completed frame
//   aer            AER event bus (master side)
//   frame_done_o   one-cycle pulse after the last event of an accepted frame (or an empty frame)
//   overrun_o      sticky: a frame_tick arrived while a frame was still being sent
//   drop_count_o   dropped-frame count, saturating at 255
//
// AW must satisfy 2**AW >= Nn so every neuron index is addressable.
module spike_aer_encoder #(
  parameter int Nn  = 4,
  parameter int AW  = 2,
  parameter int TSW = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 frame_tick_i,
  input  logic [Nn-1:0]        spikearray_i,
  spike_aer_encoder_if.master  aer,
  output logic                 frame_done_o,
  output logic                 overrun_o,
  output logic [7:0]           drop_count_o
);

  // One-hot codes so that any corrupted state register value is a distinct,
  // detectable encoding that the default branch steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SEND = 2'b10
  } state_e;

  state_e         state_q;
  logic [Nn-1:0]  pending_q;
  logic [TSW-1:0] ts_count_q;
  logic [TSW-1:0] aer_ts_q;
  logic [AW-1:0]  aer_addr_q;
  logic           aer_valid_q;
  logic           frame_done_q;
  logic           overrun_q;
  logic [7:0]     drop_count_q;

  logic           tick_en;
  logic           handshake;
  logic [Nn-1:0]  pending_d;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [AW-1:0] lowest_idx(input logic [Nn-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = Nn - 1; i >= 0; i--) begin
      if (v[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  assign tick_en   = frame_tick_i & enable_i;
  assign handshake = aer_valid_q & aer.aer_ready;
  // The event on the bus is always the lowest pending bit, so clearing the
  // lowest set bit removes exactly the event just sent.
  assign pending_d = pending_q & (pending_q - Nn'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      ts_count_q   <= '0;
      aer_ts_q     <= '0;
      aer_addr_q   <= '0;
      aer_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;

      // The frame counter advances on every enabled tick, accepted or dropped.
      if (tick_en) ts_count_q <= ts_count_q + TSW'(1);

      case (state_q)
        IDLE: begin
          aer_valid_q <= 1'b0;
          if (tick_en) begin
            aer_ts_q <= ts_count_q;
            if (spikearray_i != '0) begin
              pending_q   <= spikearray_i;
              aer_addr_q  <= lowest_idx(spikearray_i);
              aer_valid_q <= 1'b1;
              state_q     <= SEND;
            end else begin
              frame_done_q <= 1'b1;
            end
          end
        end

        SEND: begin
          if (!enable_i) begin
            // Abort: frame discarded silently, counters left alone.
            pending_q   <= '0;
            aer_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            // A tick here (even on the last handshake) belongs to a frame we
            // cannot start yet, so it is dropped.
            if (frame_tick_i) begin
              overrun_q <= 1'b1;
              if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
            end
            if (handshake) begin
              pending_q <= pending_d;
              if (pending_d != '0) begin
                aer_addr_q <= lowest_idx(pending_d);
              end else begin
                aer_valid_q  <= 1'b0;
                frame_done_q <= 1'b1;
                state_q      <= IDLE;
              end
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          pending_q   <= '0;
          aer_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign aer.aer_valid = aer_valid_q;
  assign aer.aer_addr  = aer_addr_q;
  assign aer.aer_ts    = aer_ts_q;
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;
  assign drop_count_o  = drop_count_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;
  localparam int NN  = 4;
  localparam int AW  = 2;
  localparam int TSW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic          frame_tick_i;
  logic [NN-1:0] spikearray_i;
  logic          frame_done_o;
  logic          overrun_o;
  logic [7:0]    drop_count_o;

  spike_aer_encoder_if #(.AW(AW), .TSW(TSW)) bus ();

  spike_aer_encoder #(.Nn(NN), .AW(AW), .TSW(TSW)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .frame_tick_i (frame_tick_i),
    .spikearray_i (spikearray_i),
    .aer          (bus.master),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame in flight is just the list of addresses still to be sent.
  int m_q[$];
  int m_ts_cnt, m_ts_out, m_done, m_ovr, m_drop;

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_q.delete();
      m_ts_cnt = 0; m_ts_out = 0; m_done = 0; m_ovr = 0; m_drop = 0;
    end else begin
      m_done = 0;
      if (m_q.size() != 0) begin
        if (!enable_i) m_q.delete();
        else begin
          if (frame_tick_i) begin
            m_ovr = 1;
            if (m_drop < 255) m_drop++;
          end
          if (bus.aer_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1;
          end
        end
      end else if (frame_tick_i && enable_i) begin
        m_ts_out = m_ts_cnt;
        for (int i = 0; i < NN; i++) if (spikearray_i[i]) m_q.push_back(i);
        if (m_q.size() == 0) m_done = 1;
      end
      if (frame_tick_i && enable_i) m_ts_cnt = (m_ts_cnt + 1) % 256;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    chk("valid", int'(bus.aer_valid), (m_q.size() != 0) ? 1 : 0);
    if (m_q.size() != 0) chk("addr", int'(bus.aer_addr), m_q[0]);
    chk("ts", int'(bus.aer_ts), m_ts_out);
    chk("frame_done", int'(frame_done_o), m_done);
    chk("overrun", int'(overrun_o), m_ovr);
    chk("drop_count", int'(drop_count_o), m_drop);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; enable_i = 1'b1; frame_tick_i = 1'b0;
    spikearray_i = '0; bus.aer_ready = 1'b1;
    step(); step();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b1; frame_tick_i = 1'b0;
    spikearray_i = '0; bus.aer_ready = 1'b0;
    do_reset();
    // reset values
    chk("rst_valid", int'(bus.aer_valid), 0);
    chk("rst_addr", int'(bus.aer_addr), 0);
    chk("rst_ts", int'(bus.aer_ts), 0);
    chk("rst_done", int'(frame_done_o), 0);
    chk("rst_drop", int'(drop_count_o), 0);

    // 1010, ready high: addr 1 then 3, ts 0, then done
    frame_tick_i = 1; spikearray_i = 4'b1010; step();
    frame_tick_i = 0;
    chk("f1_addr_a", int'(bus.aer_addr), 1);
    chk("f1_valid_a", int'(bus.aer_valid), 1);
    chk("f1_ts", int'(bus.aer_ts), 0);
    step();
    chk("f1_addr_b", int'(bus.aer_addr), 3);
    step();
    chk("f1_valid_end", int'(bus.aer_valid), 0);
    chk("f1_done", int'(frame_done_o), 1);

    // 0110 with three stalled cycles
    do_reset();
    bus.aer_ready = 0; frame_tick_i = 1; spikearray_i = 4'b0110; step();
    frame_tick_i = 0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_addr", int'(bus.aer_addr), 1);
      step();
    end
    chk("stall_addr4", int'(bus.aer_addr), 1);
    bus.aer_ready = 1; step();
    chk("stall_next", int'(bus.aer_addr), 2);
    step();
    chk("stall_done", int'(frame_done_o), 1);

    // three empty frames then a nonzero frame with ts 3
    do_reset();
    frame_tick_i = 1; spikearray_i = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("empty_done", int'(frame_done_o), 1);
      chk("empty_valid", int'(bus.aer_valid), 0);
    end
    spikearray_i = 4'b0001; step();
    frame_tick_i = 0;
    chk("empty_next_ts", int'(bus.aer_ts), 3);

    // overrun while stalled
    do_reset();
    bus.aer_ready = 0; frame_tick_i = 1; spikearray_i = 4'b0001; step();
    spikearray_i = 4'b1110; step();
    frame_tick_i = 0;
    chk("ovr_flag", int'(overrun_o), 1);
    chk("ovr_drop", int'(drop_count_o), 1);
    chk("ovr_addr", int'(bus.aer_addr), 0);
    chk("ovr_ts", int'(bus.aer_ts), 0);
    bus.aer_ready = 1; step(); step();

    // enable dropped after first handshake, then reset mid-SEND
    do_reset();
    frame_tick_i = 1; spikearray_i = 4'b1111; step();
    frame_tick_i = 0; step();
    chk("abort_addr", int'(bus.aer_addr), 1);
    enable_i = 0; step();
    chk("abort_valid", int'(bus.aer_valid), 0);
    chk("abort_done", int'(frame_done_o), 0);
    enable_i = 1; bus.aer_ready = 0; frame_tick_i = 1; step();
    frame_tick_i = 0;
    chk("rst_mid_valid_pre", int'(bus.aer_valid), 1);
    reset_i = 1; step();
    reset_i = 0;
    chk("rst_mid_valid", int'(bus.aer_valid), 0);
    chk("rst_mid_ts", int'(bus.aer_ts), 0);
    step();
    chk("rst_mid_done", int'(frame_done_o), 0);

    // timestamp wrap over 257 frames
    do_reset();
    spikearray_i = 4'b0001;
    for (int k = 0; k < 257; k++) begin
      frame_tick_i = 1; step();
      frame_tick_i = 0;
      chk("wrap_ts", int'(bus.aer_ts), k % 256);
      step();
    end
    // drop saturation
    bus.aer_ready = 0; frame_tick_i = 1; step();
    repeat (300) step();
    frame_tick_i = 0;
    chk("sat_drop", int'(drop_count_o), 255);
    chk("sat_ovr", int'(overrun_o), 1);
    bus.aer_ready = 1; step(); step();

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset_i       = ($urandom_range(0, 199) == 0);
      enable_i      = ($urandom_range(0, 19) != 0);
      frame_tick_i  = ($urandom_range(0, 4) == 0);
      spikearray_i  = NN'($urandom);
      bus.aer_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset_i = 0; frame_tick_i = 0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameter Nn, default 4, number of neurons (width of spike vector).
REQ-002 Parameter AW, default 2, address width; SHALL satisfy 2^AW >= Nn.
REQ-003 Parameter TSW, default 8, timestamp width (1 ms frames).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 enable  input  1  encoder enable; low aborts the current frame and holds IDLE.
REQ-007 frame_tick  input  1  one-cycle pulse marking end of a neuron computation cycle; spikearray valid in the same cycle.
REQ-008 spikearray  input  Nn  per-neuron spike flags for the completed frame.
REQ-009 aer_valid  output  1  address event available.
REQ-010 aer_ready  input  1  downstream accepts event when high with aer_valid.
REQ-011 aer_addr  output  AW  index of the spiking neuron.
REQ-012 aer_ts  output  TSW  timestamp of the frame the event belongs to.
REQ-013 frame_done  output  1  one-cycle pulse when all events of an accepted frame have been sent.
REQ-014 overrun  output  1  sticky flag: a frame_tick arrived while a frame was still in progress.
REQ-015 drop_count  output  8  number of dropped frames, saturating at 255.

Function
REQ-016 States: IDLE, SEND; no other states reachable; any illegal encoding SHALL return to IDLE next cycle.
REQ-017 ts_count (TSW bits) SHALL increment by 1 on every frame_tick with enable high, accepted or dropped, wrapping from 2^TSW-1 to 0.
REQ-018 A frame_tick is accepted only when state is IDLE and enable is high.
REQ-019 On acceptance with spikearray nonzero: pending <= spikearray, aer_ts <= ts_count (pre-increment value), state -> SEND; aer_valid SHALL be high in the next cycle.
REQ-020 On acceptance with spikearray zero: state stays IDLE, aer_ts <= ts_count, frame_done SHALL pulse in the next cycle.
REQ-021 In SEND, aer_addr SHALL equal the index of the lowest set bit of pending; aer_valid SHALL be high.
REQ-022 aer_addr, aer_ts and aer_valid SHALL stay constant while aer_valid high and aer_ready low.
REQ-023 On handshake (aer_valid and aer_ready), the sent bit SHALL be cleared from pending; if further bits remain, the next event SHALL appear in the next cycle with no bubble.
REQ-024 On handshake of the last pending bit: state -> IDLE, aer_valid low and frame_done high in the next cycle.
REQ-025 Events within a frame SHALL be sent in ascending neuron index order; exactly one event per set bit.
REQ-026 frame_tick while state is SEND (including the cycle of the last handshake) SHALL be dropped: overrun set, drop_count incremented unless at 255, pending and aer_ts unchanged.
REQ-027 enable low in SEND: pending cleared, state -> IDLE, aer_valid low next cycle, no frame_done pulse; counters and overrun unchanged.
REQ-028 enable low: frame_tick ignored entirely (no ts_count increment, no drop count).
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 On reset: state IDLE, pending 0, ts_count 0, aer_valid 0, aer_addr 0, aer_ts 0, frame_done 0, overrun 0, drop_count 0.
REQ-031 Reset mid-SEND SHALL discard the frame with no further events and no frame_done pulse.

Verification
REQ-032 Nn=4, enable=1, aer_ready=1, frame_tick with spikearray=4'b1010 -> events addr 1 then addr 3 on consecutive cycles, aer_ts=0, frame_done one cycle after second handshake.
REQ-033 spikearray=4'b0110, aer_ready low 3 cycles then high -> addr 1 held stable 4 cycles, then addr 2, then frame_done.
REQ-034 Three frame_ticks with spikearray=0 -> three frame_done pulses, no aer_valid, next nonzero frame carries aer_ts=3.
REQ-035 aer_ready=0, frame_tick with 4'b0001, then second frame_tick -> overrun=1, drop_count=1, pending unchanged, later event carries aer_ts=0.
REQ-036 enable dropped during SEND with 4'b1111 after first handshake -> aer_valid low next cycle, no frame_done; reset mid-SEND -> all outputs return to reset values.
REQ-037 256 frame_ticks with 4'b0001 -> aer_ts wraps 255 -> 0; 300 dropped frames -> drop_count saturates at 255.
